retire: RTL and testbench

In-order retirement stage of the P6 pipeline. Reads the ROB entry at the head, which the commit stage marked ready, and updates architectural state: it writes the register file, releases the rename, performs stores to data memory with a handshake, and raises a pipeline flush on a mispredicted branch. It owns the ROB head pointer and pops the ROB one entry per cycle at most.

---
 rtl/retire.sv | 125 ++++++++++++
 tb/tb_retire.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retire.sv
// In-order retirement stage: retires the ROB head entry into architectural state,
// runs stores through a data-memory handshake and flushes on a mispredicted branch.
module retire #(
  parameter int ROB_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rob_empty,
  // {valid, ready, value[31:0], dest[4:0], regwr, memwr, addr[31:0], mispredict}
  input  logic [73:0] head_entry,
  output logic [31:0] rob_head,
  output logic        rob_pop,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mt_clear,
  output logic [4:0]  mt_clear_reg,
  output logic [31:0] mt_clear_tag,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  output logic        flush,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_head, r_count, r_dmem_addr, r_dmem_wdata, w_head_next;
  logic        r_dmem_req, w_allow;

  logic        w_valid, w_ready, w_regwr, w_memwr, w_mispredict;
  logic [31:0] w_value, w_addr;
  logic [4:0]  w_dest;

  assign w_valid      = head_entry[73];
  assign w_ready      = head_entry[72];
  assign w_value      = head_entry[71:40];
  assign w_dest       = head_entry[39:35];
  assign w_regwr      = head_entry[34];
  assign w_memwr      = head_entry[33];
  assign w_addr       = head_entry[32:1];
  assign w_mispredict = head_entry[0];

  // Gating with reset keeps every combinational output low while reset is held.
  assign w_allow     = !reset && !rob_empty && w_valid && w_ready;
  assign w_head_next = (r_head == 32'(ROB_SIZE)) ? 32'd1 : r_head + 32'd1;

  always_comb begin
    w_next       = r_state;
    rob_pop      = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    mt_clear     = 1'b0;
    mt_clear_reg = '0;
    mt_clear_tag = '0;
    flush        = 1'b0;
    case (r_state)
      RUN: begin
        if (w_allow) begin
          if (w_memwr) begin
            w_next = STORE_WAIT;
          end else begin
            rob_pop = 1'b1;
            if (w_regwr && w_dest != 5'd0) begin
              rf_we    = 1'b1;
              rf_waddr = w_dest;
              rf_wdata = w_value;
            end
            if (w_regwr) begin
              mt_clear     = 1'b1;
              mt_clear_reg = w_dest;
              mt_clear_tag = r_head;
            end
            if (w_mispredict) begin
              flush  = 1'b1;
              w_next = FLUSH;
            end
          end
        end
      end
      STORE_WAIT: begin
        if (w_allow && dmem_ack) begin
          rob_pop = 1'b1;
          w_next  = RUN;
        end
      end
      FLUSH:   w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= RUN;
      r_head       <= 32'd1;
      r_count      <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (rob_pop) begin
        r_head  <= w_head_next;
        r_count <= r_count + 32'd1;
      end
      if (r_state == RUN && w_allow && w_memwr) begin
        r_dmem_req   <= 1'b1;
        r_dmem_addr  <= w_addr;
        r_dmem_wdata <= w_value;
      end else if (r_state == STORE_WAIT && rob_pop) begin
        r_dmem_req <= 1'b0;
      end
    end
  end

  assign rob_head      = r_head;
  assign retired_count = r_count;
  assign dmem_req      = r_dmem_req;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_wdata    = r_dmem_wdata;

endmodule

// File: tb/tb_retire.sv
// Scoreboard bench for retire: stimulus queues the expected retirement record,
// a monitor compares it whenever the DUT pops the ROB.
module tb_retire;

  logic        clk = 1'b0;
  logic        reset, rob_empty, dmem_ack;
  logic [73:0] head_entry;
  logic [31:0] rob_head, rf_wdata, mt_clear_tag, dmem_addr, dmem_wdata, retired_count;
  logic        rob_pop, rf_we, mt_clear, dmem_req, flush;
  logic [4:0]  rf_waddr, mt_clear_reg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mt;
    logic [4:0]  mreg;
    logic [31:0] mtag;
    logic        fl;
    logic [31:0] head;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_head;

  retire #(.ROB_SIZE(16)) dut (
    .clk(clk), .reset(reset), .rob_empty(rob_empty), .head_entry(head_entry),
    .rob_head(rob_head), .rob_pop(rob_pop), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .mt_clear(mt_clear), .mt_clear_reg(mt_clear_reg),
    .mt_clear_tag(mt_clear_tag), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .flush(flush),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_entry(input logic v, input logic r, input logic [31:0] val,
                           input logic [4:0] dest, input logic regwr, input logic memwr,
                           input logic [31:0] addr, input logic misp);
    head_entry = {v, r, val, dest, regwr, memwr, addr, misp};
  endtask

  task automatic push_exp(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic mt, input logic [4:0] mreg, input logic [31:0] mtag,
                          input logic fl, input logic [31:0] head);
    exp_t e;
    e.we = we; e.waddr = waddr; e.wdata = wdata; e.mt = mt;
    e.mreg = mreg; e.mtag = mtag; e.fl = fl; e.head = head;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inc_head(input logic [31:0] h);
    return (h == 32'd16) ? 32'd1 : h + 32'd1;
  endfunction

  // Monitor: every pop must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && rob_pop) begin
      if (sb.size() == 0) begin
        cmp("unexpected_pop", {31'd0, rob_pop}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp("pop_head", rob_head, e.head);
        cmp("pop_rf_we", {31'd0, rf_we}, {31'd0, e.we});
        if (e.we) begin
          cmp("pop_rf_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
          cmp("pop_rf_wdata", rf_wdata, e.wdata);
        end
        cmp("pop_mt_clear", {31'd0, mt_clear}, {31'd0, e.mt});
        if (e.mt) begin
          cmp("pop_mt_reg", {27'd0, mt_clear_reg}, {27'd0, e.mreg});
          cmp("pop_mt_tag", mt_clear_tag, e.mtag);
        end
        cmp("pop_flush", {31'd0, flush}, {31'd0, e.fl});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rob_empty = 1'b0; dmem_ack = 1'b0;
    set_entry(1, 1, 32'h1111, 5'd1, 1, 0, 0, 0);
    exp_head = 32'd1;
    @(negedge clk);
    cmp("rst_pop", {31'd0, rob_pop}, 32'd0);
    cmp("rst_rf_we", {31'd0, rf_we}, 32'd0);
    cmp("rst_head", rob_head, 32'd1);
    cmp("rst_req", {31'd0, dmem_req}, 32'd0);
    cmp("rst_count", retired_count, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Simple register-writing retirement at tag 1.
    set_entry(1, 1, 32'hDEADBEEF, 5'd5, 1, 0, 0, 0);
    push_exp(1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 32'd1, 0, 32'd1);
    @(negedge clk);
    cmp("first_pop", {31'd0, rob_pop}, 32'd1);
    next_cycle();
    exp_head = 32'd2;
    set_entry(1, 0, 32'h1234, 5'd7, 1, 0, 0, 0);
    dmem_ack = 1'b1;  // must be ignored in RUN
    @(negedge clk);
    cmp("head_after_first", rob_head, 32'd2);
    cmp("count_after_first", retired_count, 32'd1);

    // Not ready for 3 cycles, then ready.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      cmp("notready_pop", {31'd0, rob_pop}, 32'd0);
      cmp("notready_rf_we", {31'd0, rf_we}, 32'd0);
      cmp("notready_req", {31'd0, dmem_req}, 32'd0);
      next_cycle();
    end
    dmem_ack = 1'b0;
    set_entry(1, 1, 32'h1234, 5'd7, 1, 0, 0, 0);
    push_exp(1, 5'd7, 32'h1234, 1, 5'd7, 32'd2, 0, 32'd2);
    @(negedge clk);
    cmp("ready_cycle4_pop", {31'd0, rob_pop}, 32'd1);
    next_cycle();
    exp_head = 32'd3;

    // Store with ack delayed 3 cycles.
    set_entry(1, 1, 32'h55, 5'd9, 1, 1, 32'h100, 0);
    @(negedge clk);
    cmp("store_run_pop", {31'd0, rob_pop}, 32'd0);
    cmp("store_run_req", {31'd0, dmem_req}, 32'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("store_wait_req", {31'd0, dmem_req}, 32'd1);
      cmp("store_wait_addr", dmem_addr, 32'h100);
      cmp("store_wait_data", dmem_wdata, 32'h55);
      cmp("store_wait_pop", {31'd0, rob_pop}, 32'd0);
      next_cycle();
    end
    dmem_ack = 1'b1;
    push_exp(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 32'd3);
    @(negedge clk);
    cmp("store_ack_req", {31'd0, dmem_req}, 32'd1);
    cmp("store_ack_rf_we", {31'd0, rf_we}, 32'd0);
    next_cycle();
    exp_head = 32'd4;
    dmem_ack = 1'b0;
    set_entry(0, 0, 32'd0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("store_done_req", {31'd0, dmem_req}, 32'd0);
    cmp("store_done_head", rob_head, 32'd4);
    cmp("store_done_count", retired_count, 32'd3);
    next_cycle();

    // Back-to-back retirement across the 16 -> 1 wrap.
    for (int i = 0; i < 28; i++) begin
      logic [4:0]  d;
      logic [31:0] v;
      d = 5'((i % 31) + 1);
      v = 32'h1000_0000 + 32'(i);
      set_entry(1, 1, v, d, 1, 0, 0, 0);
      push_exp(1, d, v, 1, d, exp_head, 0, exp_head);
      @(negedge clk);
      cmp("wrap_head", rob_head, exp_head);
      next_cycle();
      exp_head = inc_head(exp_head);
    end
    cmp("wrap_final_head", rob_head, 32'd16);
    cmp("wrap_count", retired_count, 32'd31);

    // Mispredicted branch, one idle FLUSH cycle, then normal retirement.
    set_entry(1, 1, 32'hABCD, 5'd3, 1, 0, 0, 1);
    push_exp(1, 5'd3, 32'hABCD, 1, 5'd3, 32'd16, 1, 32'd16);
    @(negedge clk);
    cmp("misp_flush", {31'd0, flush}, 32'd1);
    next_cycle();
    exp_head = 32'd1;
    set_entry(1, 1, 32'h77, 5'd4, 1, 0, 0, 0);
    @(negedge clk);
    cmp("flush_idle_pop", {31'd0, rob_pop}, 32'd0);
    cmp("flush_idle_flush", {31'd0, flush}, 32'd0);
    cmp("flush_idle_mt", {31'd0, mt_clear}, 32'd0);
    cmp("flush_idle_head", rob_head, 32'd1);
    next_cycle();
    push_exp(1, 5'd4, 32'h77, 1, 5'd4, 32'd1, 0, 32'd1);
    @(negedge clk);
    next_cycle();
    exp_head = 32'd2;

    // dest=0: map table clear without a register write.
    set_entry(1, 1, 32'h99, 5'd0, 1, 0, 0, 0);
    push_exp(0, 5'd0, 32'd0, 1, 5'd0, 32'd2, 0, 32'd2);
    @(negedge clk);
    cmp("dest0_rf_we", {31'd0, rf_we}, 32'd0);
    cmp("dest0_mt", {31'd0, mt_clear}, 32'd1);
    next_cycle();
    exp_head = 32'd3;
    cmp("count_before_abort", retired_count, 32'd34);

    // Reset in the middle of STORE_WAIT abandons the store.
    set_entry(1, 1, 32'h66, 5'd0, 0, 1, 32'h200, 0);
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    cmp("abort_req_before", {31'd0, dmem_req}, 32'd1);
    #2;
    dmem_ack = 1'b1;
    reset = 1'b1;
    #1;
    cmp("abort_req", {31'd0, dmem_req}, 32'd0);
    cmp("abort_head", rob_head, 32'd1);
    cmp("abort_pop", {31'd0, rob_pop}, 32'd0);
    cmp("abort_count", retired_count, 32'd0);
    next_cycle();
    reset = 1'b0;
    dmem_ack = 1'b0;
    set_entry(0, 0, 32'd0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
